// File: rtl/prng_draw.sv
// PRNG engine (LCG or xorshift32) advancing once per clock, with runtime reseed and
// unbiased bounded draws served over a valid/ready request/response pair.
module prng_draw #(
    parameter int unsigned N     = 32,
    parameter int unsigned MODE  = 0,
    parameter int unsigned A     = 1103515245,
    parameter int unsigned C     = 12345,
    parameter int unsigned SEED  = 1,
    parameter int unsigned OUT_W = 16
) (
    input  logic             clk50M,
    input  logic             reset,
    input  logic             en,
    input  logic             seed_load,
    input  logic [N-1:0]     seed,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [OUT_W-1:0] lim,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    // 'rand' is a reserved word in SystemVerilog, hence the suffix
    output logic [N-1:0]     rand_o
);

    localparam logic [N-1:0] A_N    = N'(A);
    localparam logic [N-1:0] C_N    = N'(C);
    localparam logic [N-1:0] SEED_N = N'(SEED);

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        HOLD
    } state_t;

    state_t           state_q;
    logic [N-1:0]     rand_q;
    logic [N-1:0]     rand_d;
    logic [N-1:0]     nxt;
    logic [N-1:0]     seed_val;
    logic [OUT_W-1:0] lim_q;
    logic [OUT_W-1:0] mask_q;
    logic [OUT_W-1:0] smp;
    logic [OUT_W-1:0] cand;
    logic             accept;
    logic             req_ready_q;
    logic             out_valid_q;
    logic [OUT_W-1:0] out_data_q;

    // Smallest 2^k-1 covering lim-1; lim=0 wraps to all ones (full range).
    function automatic logic [OUT_W-1:0] mask_of(input logic [OUT_W-1:0] l);
        logic [OUT_W-1:0] m;
        m = l - OUT_W'(1);
        for (int unsigned i = 1; i < OUT_W; i = i * 2) begin
            m = m | (m >> i);
        end
        return m;
    endfunction

    always_comb begin
        logic [N-1:0] x1;
        logic [N-1:0] x2;
        logic [N-1:0] x3;
        x1  = rand_q ^ (rand_q << 13);
        x2  = x1 ^ (x1 >> 17);
        x3  = x2 ^ (x2 << 5);
        nxt = (MODE == 1) ? x3 : (rand_q * A_N + C_N);
    end

    always_comb begin
        seed_val = ((MODE == 1) && (seed == '0)) ? N'(1) : seed;
        rand_d   = rand_q;
        if (seed_load) begin
            rand_d = seed_val;
        end else if (en || (state_q == DRAW)) begin
            rand_d = nxt;
        end
    end

    assign smp    = rand_q[N-1 -: OUT_W];
    assign cand   = smp & mask_q;
    assign accept = (lim_q == '0) || (cand < lim_q);

    always_ff @(posedge clk50M) begin
        if (reset) begin
            rand_q      <= SEED_N;
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            lim_q       <= '0;
            mask_q      <= '0;
        end else begin
            rand_q <= rand_d;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        lim_q       <= lim;
                        mask_q      <= mask_of(lim);
                        req_ready_q <= 1'b0;
                        state_q     <= DRAW;
                    end
                end
                DRAW: begin
                    if (accept) begin
                        out_data_q  <= cand;
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    req_ready_q <= 1'b1;
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign rand_o    = rand_q;

endmodule
